if_fetch_queue: RTL
===================

Name: if_fetch_queue

Overview:
Parametrised instruction-fetch unit for the pipelined MIPS core. It generates sequential PCs from a configurable reset vector and drives a synchronous instruction ROM with 1-cycle read latency. Returned words go into a small instruction queue that decode drains through a valid/ready handshake. A redirect from branch/jump resolution flushes the queue and any in-flight fetch, and restarts fetch at the target.

Parameters:
RESET_PC, 32'h00003000, PC loaded on reset
IM_ADDR_W, 8, word-address width of the instruction ROM (im_addr = pc[IM_ADDR_W+1:2])
DEPTH, 4, instruction queue entries; power of two, >= 2

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
redir_valid  input  1  redirect request, sampled each cycle
redir_pc  input  32  redirect target; bits [1:0] ignored (forced to 0)
im_en  output  1  ROM read enable (fetch issued this cycle)
im_addr  output  IM_ADDR_W  ROM word address
im_rdata  input  32  ROM data, valid the cycle after im_en
out_valid  output  1  queue head holds a valid instruction
out_instr  output  32  head instruction
out_pc  output  32  PC of head instruction
out_ready  input  1  decode accepts head when out_valid=1
busy_count  output  clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset (rst_n=0, asynchronous): fetch_pc=RESET_PC, queue empty (count=0, rd/wr pointers 0), inflight=0. out_valid=0, im_en=0, busy_count=0, out_instr/out_pc=0.
- Issue rule: im_en=1 iff rst_n=1 AND redir_valid=0 AND (count + inflight) < DEPTH. count excludes any same-cycle dequeue (conservative credit).
- im_addr = fetch_pc[IM_ADDR_W+1:2] (combinational). On issue: fetch_pc <= fetch_pc+4 (32-bit wrap), inflight <= 1, inflight_pc <= fetch_pc. Otherwise inflight <= 0.
- Return: if inflight=1 in cycle c, im_rdata is written with inflight_pc at the tail at end of c.
- Latency: issue in cycle c -> entry written end of c+1 -> out_valid in c+2. No bypass.
- Dequeue: out_valid & out_ready pops head at edge. Enqueue and dequeue in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- The credit rule makes overflow impossible. An enqueue while count==DEPTH is a design error; assert it in simulation.
- Redirect (redir_valid=1 in cycle t), highest priority:
  - at end of t: queue cleared (count=0, pointers 0), inflight cleared (returning word discarded), fetch_pc <= {redir_pc[31:2],2'b00}.
  - im_en=0 in t. A dequeue handshake in t still counts as consumed by decode. The queue is cleared regardless.
  - out_valid=0 in t+1. First target fetch issues in t+1. Target instruction reaches out_valid in t+3.
  - Back-to-back redirects: the last one wins; no fetch issues while redir_valid stays high.
- ROM address wrap: fetch_pc wraps through full 32 bits. im_addr truncates, so the ROM word address wraps at 2^IM_ADDR_W while out_pc carries the full PC.
- Reset mid-operation: immediate return to reset state, asynchronously, including an in-flight fetch (dropped). First issue is the first clk edge with rst_n=1, at RESET_PC.
- Outputs out_instr/out_pc are undefined-but-stable (last head contents) when out_valid=0; the bench must not check them then.

Test Plan:
- Reset release, out_ready=1 -> im_en cycles 0,1,2…; im_addr 0x00,0x01,0x02; out_valid from cycle 2; out_pc 0x3000,0x3004,0x3008 one per cycle.
- out_ready=0 for 10 cycles, DEPTH=4 -> busy_count reaches 4, im_en stays 0 afterwards. Raise out_ready -> 4 queued PCs in order, then fetch resumes with no gap >2 cycles and no lost/duplicated PC.
- Queue holding 2 entries plus inflight; redir_valid=1, redir_pc=0x3043 -> out_valid=0 next cycle, busy_count=0, stale word not enqueued; next im_addr=0x10; out_pc=0x3040 three cycles after redirect.
- Redirect coincident with out_valid&out_ready -> head counted consumed once; no entry from the old stream appears afterwards.
- Redirect to 0x3000+4*(2^IM_ADDR_W−1) -> im_addr 0xFF then 0x00; out_pc 0x33FC then 0x3400.
- Assert rst_n low mid-stream with inflight=1, asynchronously between edges -> out_valid, im_en, busy_count drop to 0 immediately. After release, stream restarts at 0x3000.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction-fetch unit: a sequential PC generator that drives a 1-cycle
// synchronous instruction ROM and collects the returned words in a small
// FIFO for decode to drain.
//
// Handshake: the head entry is transferred when out_valid && out_ready are
// both high at a rising clk edge; out_valid never depends on out_ready, and
// once raised the head stays put until it is accepted or a redirect flushes it.
//
// A redirect flushes the queue and any in-flight fetch and restarts fetch at
// the target. Fetch is throttled by a conservative credit: queued entries
// plus the in-flight fetch must stay below DEPTH, so a returning word always
// has a free slot.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          IM_ADDR_W = 8,
    parameter int          DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redir_valid,
    input  logic [31:0]                redir_pc,
    output logic                       im_en,
    output logic [IM_ADDR_W-1:0]       im_addr,
    input  logic [31:0]                im_rdata,
    output logic                       out_valid,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     busy_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] credit;
    logic [31:0]   redir_tgt;
    logic          enq;
    logic          deq;

    // Redirect target is always word aligned.
    assign redir_tgt = redir_pc & 32'hFFFF_FFFC;

    // Credit counts what is queued plus what is still coming back from the
    // ROM; a dequeue in the same cycle is deliberately not credited.
    assign credit    = count + {{(CW-1){1'b0}}, inflight};
    assign im_en     = rst_n & ~redir_valid & (credit < CW'(DEPTH));
    assign im_addr   = fetch_pc[IM_ADDR_W+1:2];

    // A redirect discards the returning word and makes the flush win over
    // any handshake (the accepted head is still consumed by decode).
    assign enq        = inflight & ~redir_valid;
    assign out_valid  = (count != '0);
    assign deq        = out_valid & out_ready & ~redir_valid;
    assign out_instr  = instr_q[rd_ptr];
    assign out_pc     = pc_q[rd_ptr];
    assign busy_count = count;

    // Fetch PC and in-flight tracking; redirect restarts at the target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redir_valid) begin
            fetch_pc <= redir_tgt;
            inflight <= 1'b0;
        end else begin
            inflight <= im_en;
            if (im_en) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
            end
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redir_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            if (enq && !deq)      count <= count + 1'b1;
            else if (!enq && deq) count <= count - 1'b1;
        end
    end

    // Queue storage: returning ROM word tagged with the PC that fetched it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (enq) begin
            instr_q[wr_ptr] <= im_rdata;
            pc_q[wr_ptr]    <= inflight_pc;
        end
    end

    // The credit rule must make a write into a full queue impossible.
    always_ff @(posedge clk) begin
        assert (!(enq && count == CW'(DEPTH)));
    end

endmodule
